// File: rtl/bin_stim_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bin_stim_gen_pkg
// Description : Shared definitions for the binary-counter stimulus sequencer:
//               4-bit state encoding, LFSR tap mask and a sizing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bin_stim_gen_pkg;

    // Script phases, fixed 4-bit encoding shared with the counter bench
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_CLR   = 4'd1,
        ST_LOAD  = 4'd2,
        ST_UP    = 4'd3,
        ST_PAUSE = 4'd4,
        ST_DOWN  = 4'd5,
        ST_RAND  = 4'd6,
        ST_COLL  = 4'd7,
        ST_DONE  = 4'd8
    } stim_state_t;

    // Fibonacci taps 16,14,13,11 expressed on bits [15:0]
    localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;

    // Largest of three phase lengths, used to size the shared phase timer
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage : bin_stim_gen_pkg
`default_nettype wire

// File: rtl/stim_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : stim_lfsr
// Description : 16-bit Fibonacci LFSR with reload and advance controls.
//               Reset value is RESET_SEED; reload takes the seed input.
// Revision    : 1.0 - initial release
// ============================================================================
module stim_lfsr
    import bin_stim_gen_pkg::*;
#(
    parameter logic [15:0] RESET_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    input  logic        reload,
    input  logic        advance,
    output logic [15:0] value
);

    logic [15:0] r_q;
    logic        w_fb;

    // XOR of the tapped bits feeds the low end of the shift register
    assign w_fb  = ^(r_q & LFSR_TAP_MASK);
    assign value = r_q;

    // Reload has priority over advance so a run always restarts on the seed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= RESET_SEED;
        end else if (reload) begin
            r_q <= seed;
        end else if (advance) begin
            r_q <= {r_q[14:0], w_fb};
        end
    end

endmodule : stim_lfsr
`default_nettype wire

// File: rtl/bin_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : bin_stim_gen
// Description : Directed-stimulus sequencer for a universal binary counter.
//               Script: clear, load, up-count, pause, down-count,
//               [random], clear/load collision, done.
//               Optional macro STIM_RAND_EN inserts an LFSR-driven random
//               phase between DOWN and COLL.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_stim_gen
    import bin_stim_gen_pkg::*;
#(
    parameter int          N         = 3,
    parameter int          UP_CYC    = 10,
    parameter int          PAUSE_CYC = 2,
    parameter int          LOAD_VAL  = 5,
    parameter int          RAND_CYC  = 16,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         syn_clr,
    output logic         load,
    output logic         en,
    output logic         up,
    output logic [N-1:0] d,
    output logic         busy,
    output logic         done
);

    localparam int TW = $clog2(max3(UP_CYC, PAUSE_CYC, RAND_CYC) + 1);

    localparam logic [TW-1:0] c_up_last    = TW'(UP_CYC - 1);
    localparam logic [TW-1:0] c_pause_last = TW'(PAUSE_CYC - 1);
    localparam logic [N-1:0]  c_load_d     = N'(LOAD_VAL);

    stim_state_t   r_state;
    stim_state_t   w_state_nxt;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;

    logic          w_syn_clr;
    logic          w_load;
    logic          w_en;
    logic          w_up;
    logic [N-1:0]  w_d;
    logic          w_busy;
    logic          w_done;

`ifdef STIM_RAND_EN
    localparam logic [TW-1:0] c_rand_last = TW'(RAND_CYC - 1);

    logic [15:0] w_lfsr;

    stim_lfsr #(
        .RESET_SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .seed    (SEED),
        .reload  (w_state_nxt == ST_CLR),
        .advance (1'b1),
        .value   (w_lfsr)
    );
`endif

    // Next-state / phase-timer logic, then registered-output values for the next state
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_syn_clr   = 1'b0;
        w_load      = 1'b0;
        w_en        = 1'b0;
        w_up        = 1'b0;
        w_d         = d;
        w_busy      = 1'b0;
        w_done      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_CLR;
            end
            ST_CLR: begin
                w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_state_nxt = ST_UP;
                w_timer_nxt = c_up_last;
            end
            ST_UP: begin
                if (r_timer == '0) begin
                    w_state_nxt = ST_PAUSE;
                    w_timer_nxt = c_pause_last;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            ST_PAUSE: begin
                if (r_timer == '0) begin
                    w_state_nxt = ST_DOWN;
                    w_timer_nxt = c_up_last;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            ST_DOWN: begin
                if (r_timer == '0) begin
`ifdef STIM_RAND_EN
                    w_state_nxt = ST_RAND;
                    w_timer_nxt = c_rand_last;
`else
                    w_state_nxt = ST_COLL;
`endif
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
`ifdef STIM_RAND_EN
            ST_RAND: begin
                if (r_timer == '0) begin
                    w_state_nxt = ST_COLL;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
`endif
            ST_COLL: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Moore outputs are decoded from the state being entered
        case (w_state_nxt)
            ST_CLR: begin
                w_syn_clr = 1'b1;
                w_busy    = 1'b1;
            end
            ST_LOAD: begin
                w_load = 1'b1;
                w_d    = c_load_d;
                w_busy = 1'b1;
            end
            ST_UP: begin
                w_en   = 1'b1;
                w_up   = 1'b1;
                w_busy = 1'b1;
            end
            ST_PAUSE: begin
                w_up   = 1'b1;
                w_busy = 1'b1;
            end
            ST_DOWN: begin
                w_en   = 1'b1;
                w_busy = 1'b1;
            end
`ifdef STIM_RAND_EN
            ST_RAND: begin
                w_syn_clr = &w_lfsr[3:0];
                w_load    = &w_lfsr[6:5];
                w_en      = w_lfsr[7];
                w_up      = w_lfsr[8];
                w_d       = w_lfsr[N+8:9];
                w_busy    = 1'b1;
            end
`endif
            ST_COLL: begin
                w_syn_clr = 1'b1;
                w_load    = 1'b1;
                w_en      = 1'b1;
                w_up      = 1'b1;
                w_d       = ~c_load_d;
                w_busy    = 1'b1;
            end
            ST_DONE: begin
                w_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State, phase timer and every output are registered; reset aborts any run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            syn_clr <= 1'b0;
            load    <= 1'b0;
            en      <= 1'b0;
            up      <= 1'b0;
            d       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            syn_clr <= w_syn_clr;
            load    <= w_load;
            en      <= w_en;
            up      <= w_up;
            d       <= w_d;
            busy    <= w_busy;
            done    <= w_done;
        end
    end

endmodule : bin_stim_gen
`default_nettype wire

// File: tb/tb_bin_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_stim_gen
// Description : Self-checking bench for bin_stim_gen driving a 3-bit
//               universal counter model (clear > load > enable).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_stim_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       syn_clr;
    logic       load;
    logic       en;
    logic       up;
    logic [2:0] d;
    logic       busy;
    logic       done;
    logic [2:0] cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bin_stim_gen dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .syn_clr (syn_clr),
        .load    (load),
        .en      (en),
        .up      (up),
        .d       (d),
        .busy    (busy),
        .done    (done)
    );

    // Downstream counter under test: clear has priority over load over count
    always @(posedge clk or posedge reset) begin
        if (reset)        cnt <= 3'd0;
        else if (syn_clr) cnt <= 3'd0;
        else if (load)    cnt <= d;
        else if (en)      cnt <= up ? cnt + 3'd1 : cnt - 3'd1;
    end

    // cmd bits: {syn_clr, load, en, up, busy, done}
    typedef struct {
        logic       rst;
        logic       st;
        logic [5:0] cmd;
        logic [2:0] dv;
        logic [2:0] cv;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] pack(input logic [5:0] c, input logic [2:0] dd,
                                         input logic [2:0] cv);
        return {20'd0, c, dd, cv};
    endfunction

    function automatic logic [31:0] outs();
        return {20'd0, syn_clr, load, en, up, busy, done, d, cnt};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic push(input logic r, input logic s, input logic [5:0] c,
                        input logic [2:0] dd, input logic [2:0] cv);
        vec_t v;
        v.rst = r; v.st = s; v.cmd = c; v.dv = dd; v.cv = cv;
        tbl.push_back(v);
    endtask

    // One complete script run; noisy adds ignored start pulses in UP and DOWN
    task automatic add_run(input bit noisy, input logic [2:0] d_prev, input logic [2:0] c_prev);
        push(1'b0, 1'b1, 6'b100010, d_prev, c_prev);
        push(1'b0, 1'b0, 6'b010010, 3'd5, 3'd0);
        for (int k = 0; k < 10; k++) push(1'b0, noisy && (k == 3), 6'b001110, 3'd5, 3'(5 + k));
        for (int k = 0; k < 2; k++)  push(1'b0, 1'b0, 6'b000110, 3'd5, 3'd7);
        for (int k = 0; k < 10; k++) push(1'b0, noisy && (k == 4), 6'b001010, 3'd5, 3'(7 - k));
        push(1'b0, 1'b0, 6'b111110, 3'd2, 3'd5);
        push(1'b0, 1'b0, 6'b000001, 3'd2, 3'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;

`ifndef STIM_RAND_EN
        // Reset, idle, clean run, idle, run with ignored start pulses, idle
        for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 6'b000000, 3'd0, 3'd0);
        for (int i = 0; i < 2; i++) push(1'b0, 1'b0, 6'b000000, 3'd0, 3'd0);
        add_run(1'b0, 3'd0, 3'd0);
        for (int i = 0; i < 2; i++) push(1'b0, 1'b0, 6'b000000, 3'd2, 3'd0);
        add_run(1'b1, 3'd2, 3'd0);
        push(1'b0, 1'b0, 6'b000000, 3'd2, 3'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst;
            start = tbl[i].st;
            tick();
            chk($sformatf("vec%0d", i), outs(), pack(tbl[i].cmd, tbl[i].dv, tbl[i].cv));
        end

        // Reset asserted mid-UP clears outputs without waiting for a clock
        begin
            int cyc;
            start = 1'b1; tick(); start = 1'b0;
            chk("mid_clr", outs(), pack(6'b100010, 3'd2, 3'd0));
            for (int i = 0; i < 4; i++) tick();
            chk("mid_up3", outs(), pack(6'b001110, 3'd5, 3'd7));
            reset = 1'b1;
            #1;
            chk("async_rst", outs(), pack(6'b000000, 3'd0, 3'd0));
            tick();
            reset = 1'b0;
            tick();
            chk("post_rst_idle", outs(), pack(6'b000000, 3'd0, 3'd0));
            start = 1'b1; tick(); start = 1'b0;
            chk("replay_clr", outs(), pack(6'b100010, 3'd0, 3'd0));
            tick();
            chk("replay_load", outs(), pack(6'b010010, 3'd5, 3'd0));
            cyc = 0;
            while (!done && cyc < 40) begin
                tick();
                cyc++;
            end
            chk("replay_done_latency", 32'(cyc), 32'd24);
            chk("replay_final_cnt", {29'd0, cnt}, 32'd0);
        end

        // start held high: back-to-back runs with one IDLE cycle in between
        begin
            int dcount, first_done, second_clr, cyc;
            logic idle_gap;
            dcount = 0; first_done = -1; second_clr = -1; idle_gap = 1'b0;
            tick();
            start = 1'b1;
            for (int c = 1; c <= 60; c++) begin
                tick();
                if (done) begin
                    dcount++;
                    if (first_done < 0) first_done = c;
                end
                if (first_done > 0 && c == first_done + 1)
                    idle_gap = !busy && !done && !syn_clr && !load && !en && !up;
                if (syn_clr && !load && first_done > 0 && second_clr < 0) second_clr = c;
            end
            chk("held_done_count", 32'(dcount), 32'd2);
            chk("held_first_done", 32'(first_done), 32'd26);
            chk("held_idle_gap", {31'd0, idle_gap}, 32'd1);
            chk("held_second_clr", 32'(second_clr), 32'd28);
            start = 1'b0;
            cyc = 0;
            while (!done && cyc < 40) begin
                tick();
                cyc++;
            end
            chk("held_third_done", {31'd0, done}, 32'd1);
            tick();
            chk("held_final_idle", outs(), pack(6'b000000, 3'd2, 3'd0));
        end
`else
        // Random phase build: busy length and repeatability of the command stream
        begin
            logic [31:0] s0[$];
            logic [31:0] s1[$];
            int blen;
            repeat (3) tick();
            reset = 1'b0;
            tick();
            for (int r = 0; r < 2; r++) begin
                start = 1'b1; tick(); start = 1'b0;
                blen = 0;
                while (busy && blen < 100) begin
                    if (r == 0) s0.push_back(outs());
                    else        s1.push_back(outs());
                    tick();
                    blen++;
                end
                chk($sformatf("rand_busy_len%0d", r), 32'(blen), 32'd41);
                chk($sformatf("rand_done%0d", r), {31'd0, done}, 32'd1);
                chk($sformatf("rand_cnt_after%0d", r), {29'd0, cnt}, 32'd0);
                tick();
            end
            chk("rand_stream_len", 32'(s1.size()), 32'(s0.size()));
            for (int i = 0; i < s0.size() && i < s1.size(); i++)
                if (s0[i] !== s1[i]) chk($sformatf("rand_stream%0d", i), s1[i], s0[i]);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bin_stim_gen
`default_nettype wire
